input_rc_unit: RTL and testbench
================================

// Module: input_rc_unit
// PURPOSE
//  Per-input-port front end of the NoC router. Buffers incoming flits in a FIFO.
//  Presents head-flit routing fields to the route decoder (dec_rt) and latches
//  its result: output port, pruned multicast bitmap, multicast absorb flag.
//  Then requests the switch allocator and streams the packet head-to-tail.
//  It rewrites the head flit's multicast bitmap with the pruned bitmap.
//  Returns one credit upstream per flit popped.
// PARAMETERS
//  FLITW  36  flit width. Flit fields:
//             [35] head, [34] tail, [33] um_type, [32:28] addr0 (x*4+y),
//             [27:8] addr1 (20-node multicast bitmap), [7:0] payload.
//  DEPTH  4   FIFO entries; must be a power of 2, at least 2.
//  PORTW  2   port field msb; port bus is [PORTW:0].
// PORTS
//  clk            in   1          clock, rising edge
//  rst_           in   1          asynchronous reset, active-low
//  idata          in   FLITW      flit from upstream link
//  ivalid         in   1          idata valid this cycle
//  ocredit        out  1          1-cycle pulse per flit freed
//  dec_um_type    out  1          to decoder: head um_type
//  dec_addr0      out  5          to decoder: head addr0
//  dec_addr1      out  20         to decoder: head addr1
//  dec_port       in   PORTW+1    from decoder: output port
//  dec_addr1_rm   in   20         from decoder: bitmap with own bit cleared
//  dec_multab_en  in   1          from decoder: this node absorbs (multicast)
//  req            out  1          switch request
//  req_port       out  PORTW+1    latched output port
//  req_absorb     out  1          latched absorb flag
//  grant          in   1          switch grant; pops one flit when req=1
//  odata          out  FLITW      flit to crossbar (registered)
//  ovalid         out  1          odata valid
//  err            out  1          sticky error (overflow or protocol)
// BEHAVIOUR
//  Reset (async, rst_=0):
//   - FIFO pointers and count = 0; state = IDLE.
//   - req, ovalid, ocredit, err = 0; req_port, req_absorb, odata = 0.
//  FIFO:
//   - ivalid writes idata at the clock edge; the entry is at the head next cycle.
//   - Write while full (count==DEPTH): flit dropped, err<=1.
//   - Simultaneous write and pop when full: legal, count unchanged.
//   - Pointers wrap modulo DEPTH.
//  dec_* outputs are combinational from the FIFO head fields, always driven.
//  FSM:
//   - IDLE: FIFO non-empty and head bit=1 -> RC.
//     FIFO non-empty and head bit=0 -> pop and discard, ocredit pulse, err<=1,
//     stay IDLE.
//   - RC (exactly 1 cycle): latch dec_port->req_port,
//     dec_multab_en->req_absorb, dec_addr1_rm->rm_reg; -> ACTIVE.
//   - ACTIVE: req=1 while FIFO non-empty (req=0 when empty, packet stalls).
//     grant&&req pops the head flit:
//       odata<=flit, with [27:8] replaced by rm_reg if it is the head flit;
//       ovalid<=1 next cycle; ocredit pulses the cycle after the pop.
//     Popped flit with tail=1 -> IDLE.
//   - Head+tail flit (single flit packet) returns to IDLE after 1 pop.
//  Timing:
//   - Head written at edge E0 -> IDLE sees it in cycle 1 -> RC in cycle 2
//     -> req=1 in cycle 3.
//   - With grant held, one flit per cycle.
//  Signal rules:
//   - grant while req=0: ignored.
//   - ovalid=0 in any cycle with no pop in the previous cycle.
//   - Unicast (um_type=0): rm_reg = dec_addr1_rm (0 from decoder), head
//     bitmap field cleared.
//   - Reset mid-packet: FIFO contents discarded, no credits returned.
// TESTING
//  1. Unicast 3-flit packet, addr0=5'd9, grant held:
//     req at cycle 3, req_port = decoder port;
//     odata head/body/tail on consecutive cycles; 3 ocredit pulses.
//  2. Multicast head at node (1,0), addr1 bits 4 and 12 set:
//     req_absorb=1; forwarded head [27:8] has bit 4 cleared, bit 12 kept.
//  3. Fill DEPTH flits with grant=0, then one more ivalid:
//     flit dropped, err=1, count stays DEPTH.
//     Release grant: exactly DEPTH flits out.
//  4. Full FIFO with ivalid and grant in the same cycle:
//     no drop, err stays 0, order preserved.
//  5. Body flit arrives while IDLE: discarded, one ocredit, err=1, req never set.
//  6. rst_ low mid-packet, asynchronous to clk:
//     req, ovalid, ocredit = 0 immediately; after release, a fresh head
//     routes normally.

Source files
------------

// File: rtl/input_rc_unit.sv
// input_rc_unit: per-input-port NoC router front end; buffers flits, routes the head, streams the packet.
//   clk, rst_                    clock (rising edge), asynchronous active-low reset
//   idata, ivalid                flit from upstream link
//   ocredit                      one-cycle pulse per flit freed from the FIFO
//   dec_um_type/addr0/addr1      FIFO head routing fields to the route decoder
//   dec_port/addr1_rm/multab_en  decoder result, latched during route compute
//   req, req_port, req_absorb    switch allocator request and latched route
//   grant                        switch grant, pops one flit while req is high
//   odata, ovalid                registered flit to the crossbar
//   err                          sticky overflow / protocol error
module input_rc_unit #(
    parameter int FLITW = 36,
    parameter int DEPTH = 4,
    parameter int PORTW = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata,
    input  logic             ivalid,
    output logic             ocredit,
    output logic             dec_um_type,
    output logic [4:0]       dec_addr0,
    output logic [19:0]      dec_addr1,
    input  logic [PORTW:0]   dec_port,
    input  logic [19:0]      dec_addr1_rm,
    input  logic             dec_multab_en,
    output logic             req,
    output logic [PORTW:0]   req_port,
    output logic             req_absorb,
    input  logic             grant,
    output logic [FLITW-1:0] odata,
    output logic             ovalid,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RC, ACTIVE} state_t;
    state_t           state_q, state_d;
    logic [FLITW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic [19:0]      rm_q;
    logic [PORTW:0]   port_q;
    logic [FLITW-1:0] odata_q, head, fwd_flit;
    logic             req_q, req_d, ovalid_q, ocredit_q, err_q, absorb_q;
    logic             empty, full, discard, fwd, pop, push;

    always_comb begin
        head     = mem_q[rp_q];
        empty    = cnt_q == '0;
        full     = cnt_q == (AW+1)'(DEPTH);
        // a non-head flit at the FIFO head while idle has no packet to belong to
        discard  = state_q == IDLE && !empty && !head[FLITW-1];
        fwd      = req_q && grant;
        pop      = discard || fwd;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push     = ivalid && (!full || pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d  = state_q == IDLE ? (!empty && head[FLITW-1] ? RC : IDLE) :
                   state_q == RC ? ACTIVE :
                   fwd && head[FLITW-2] ? IDLE : ACTIVE;
        // registered request: high next cycle iff active with a flit waiting
        req_d    = state_d == ACTIVE && cnt_d != '0;
        fwd_flit = head[FLITW-1] ? {head[FLITW-1:28], rm_q, head[7:0]} : head;
    end

    assign dec_um_type = head[FLITW-3];
    assign dec_addr0   = head[32:28];
    assign dec_addr1   = head[27:8];
    assign req         = req_q;
    assign req_port    = port_q;
    assign req_absorb  = absorb_q;
    assign odata       = odata_q;
    assign ovalid      = ovalid_q;
    assign ocredit     = ocredit_q;
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= idata;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            rm_q      <= '0;
            port_q    <= '0;
            absorb_q  <= 1'b0;
            req_q     <= 1'b0;
            ovalid_q  <= 1'b0;
            ocredit_q <= 1'b0;
            err_q     <= 1'b0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_q + AW'(push);
            rp_q      <= rp_q + AW'(pop);
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            ovalid_q  <= fwd;
            ocredit_q <= pop;
            err_q     <= err_q || (ivalid && !push) || discard;
            if (fwd) odata_q <= fwd_flit;
            if (state_q == RC) begin
                port_q   <= dec_port;
                absorb_q <= dec_multab_en;
                rm_q     <= dec_addr1_rm;
            end
        end
    end
endmodule

// File: tb/tb_input_rc_unit.sv
// tb_input_rc_unit: directed and credit-driven random checks of input_rc_unit against a packet-level model.
module tb_input_rc_unit;
    localparam int FLITW = 36;
    localparam int DEPTH = 4;
    localparam int PORTW = 2;
    localparam int ME    = 4;

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic [FLITW-1:0] idata = '0;
    logic             ivalid = 1'b0;
    logic             ocredit;
    logic             dec_um_type;
    logic [4:0]       dec_addr0;
    logic [19:0]      dec_addr1;
    logic [PORTW:0]   dec_port;
    logic [19:0]      dec_addr1_rm;
    logic             dec_multab_en;
    logic             req;
    logic [PORTW:0]   req_port;
    logic             req_absorb;
    logic             grant = 1'b0;
    logic [FLITW-1:0] odata;
    logic             ovalid;
    logic             err;

    typedef struct {
        logic [FLITW-1:0] f;
        logic [PORTW:0]   port;
        logic             ab;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cred  = 0;
    int   n_ov    = 0;

    always #5 clk = ~clk;

    input_rc_unit #(.FLITW(FLITW), .DEPTH(DEPTH), .PORTW(PORTW)) dut (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ocredit(ocredit),
        .dec_um_type(dec_um_type), .dec_addr0(dec_addr0), .dec_addr1(dec_addr1),
        .dec_port(dec_port), .dec_addr1_rm(dec_addr1_rm), .dec_multab_en(dec_multab_en),
        .req(req), .req_port(req_port), .req_absorb(req_absorb), .grant(grant),
        .odata(odata), .ovalid(ovalid), .err(err)
    );

    // route decoder stand-in for node (1,0): port = addr0 mod 5, own bitmap bit is 4
    always_comb begin
        dec_port      = 3'(dec_addr0 % 5);
        dec_addr1_rm  = dec_um_type ? (dec_addr1 & ~(20'(1) << ME)) : 20'd0;
        dec_multab_en = dec_um_type && dec_addr1[ME];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FLITW-1:0] mk(input logic h, input logic t, input logic um,
                                            input logic [4:0] a0, input logic [19:0] a1,
                                            input logic [7:0] pl);
        return {h, t, um, a0, a1, pl};
    endfunction

    task automatic expect_flit(input logic [FLITW-1:0] f);
        exp_t e;
        e.f = f;
        if (f[35]) e.f[27:8] = f[33] ? (f[27:8] & ~(20'(1) << ME)) : 20'd0;
        e.port = 3'(f[32:28] % 5);
        e.ab = f[33] && f[8+ME];
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [FLITW-1:0] d, input logic g);
        @(posedge clk);
        #1;
        ivalid = v;
        idata  = d;
        grant  = g;
    endtask

    task automatic idle(input int n, input logic g);
        repeat (n) step(1'b0, '0, g);
    endtask

    task automatic do_reset();
        #2 rst_ = 1'b0;
        ivalid = 1'b0;
        grant  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_ = 1'b1;
        n_cred = 0;
        n_ov   = 0;
    endtask

    task automatic wait_ov(input string tag, output logic [FLITW-1:0] d);
        bit seen;
        seen = 1'b0;
        d = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ovalid) begin
                seen = 1'b1;
                d = odata;
            end
        end
        chk(tag, seen, 1);
    endtask

    // output monitor: every forwarded flit against the packet-level expectation
    initial begin
        exp_t e;
        logic pop_prev;
        pop_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_) begin
                chk("ovalid_vs_pop", ovalid, pop_prev);
                if (ovalid) begin
                    n_ov++;
                    chk("exp_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("odata", odata, e.f);
                        if (e.f[35]) begin
                            chk("req_port", req_port, e.port);
                            chk("req_absorb", req_absorb, e.ab);
                        end
                    end
                end
                if (ocredit) n_cred++;
                pop_prev = req && grant;
            end else begin
                pop_prev = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FLITW-1:0] f0, f1, f2, f3, fx, d;
        logic [FLITW-1:0] src_q[$];
        int len, sent, total;
        logic um, g;
        logic [4:0] a0;
        logic [19:0] a1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_ocredit", ocredit, 0);
        chk("rst_err", err, 0);
        chk("rst_req_port", req_port, 0);
        chk("rst_req_absorb", req_absorb, 0);
        chk("rst_odata", odata, 0);
        #2 rst_ = 1'b1;

        // unicast 3-flit packet, grant held
        f0 = mk(1, 0, 0, 5'd9, 20'hABCDE, 8'h11);
        f1 = mk(0, 0, 0, 5'd3, 20'h12345, 8'h22);
        f2 = mk(0, 1, 0, 5'd7, 20'h0F0F0, 8'h33);
        expect_flit(f0);
        expect_flit(f1);
        expect_flit(f2);
        step(1, f0, 1);
        step(1, f1, 1);
        @(negedge clk);
        chk("t1_req_c1", req, 0);
        step(1, f2, 1);
        @(negedge clk);
        chk("t1_req_c2", req, 0);
        step(0, '0, 1);
        @(negedge clk);
        chk("t1_req_c3", req, 1);
        chk("t1_port", req_port, 3'd4);
        repeat (3) begin
            @(negedge clk);
            chk("t1_ovalid_seq", ovalid, 1);
        end
        @(negedge clk);
        chk("t1_ovalid_end", ovalid, 0);
        chk("t1_req_end", req, 0);
        step(0, '0, 0);
        chk("t1_credits", n_cred, 3);
        chk("t1_drained", exp_q.size(), 0);

        // multicast head+tail at node (1,0), bitmap bits 4 and 12
        f0 = mk(1, 1, 1, 5'd2, (20'(1) << 4) | (20'(1) << 12), 8'h5A);
        expect_flit(f0);
        step(1, f0, 1);
        step(0, '0, 1);
        wait_ov("t2_out", d);
        chk("t2_absorb", req_absorb, 1);
        chk("t2_bit4", d[8+4], 0);
        chk("t2_bit12", d[8+12], 1);
        idle(3, 0);
        chk("t2_err", err, 0);

        // overflow: DEPTH flits held, one more dropped
        do_reset();
        f0 = mk(1, 0, 0, 5'd1, 20'h00001, 8'hA0);
        f1 = mk(0, 0, 0, 5'd0, 20'h00002, 8'hA1);
        f2 = mk(0, 0, 0, 5'd0, 20'h00003, 8'hA2);
        f3 = mk(0, 0, 0, 5'd0, 20'h00004, 8'hA3);
        fx = mk(0, 1, 0, 5'd0, 20'h00005, 8'hA4);
        expect_flit(f0);
        expect_flit(f1);
        expect_flit(f2);
        expect_flit(f3);
        step(1, f0, 0);
        step(1, f1, 0);
        step(1, f2, 0);
        step(1, f3, 0);
        @(negedge clk);
        chk("t3_err_before", err, 0);
        step(1, fx, 0);
        step(0, '0, 0);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_req", req, 1);
        idle(12, 1);
        chk("t3_out_count", n_ov, DEPTH);
        chk("t3_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("t3_req_empty", req, 0);

        // full FIFO with simultaneous write and pop
        do_reset();
        fx = mk(0, 1, 0, 5'd0, 20'h00005, 8'hA4);
        expect_flit(f0);
        expect_flit(f1);
        expect_flit(f2);
        expect_flit(f3);
        expect_flit(fx);
        step(1, f0, 0);
        step(1, f1, 0);
        step(1, f2, 0);
        step(1, f3, 0);
        idle(2, 0);
        @(negedge clk);
        chk("t4_full_req", req, 1);
        step(1, fx, 1);
        step(0, '0, 1);
        idle(10, 1);
        chk("t4_out", n_ov, 5);
        chk("t4_err", err, 0);
        chk("t4_drained", exp_q.size(), 0);

        // body flit while idle
        do_reset();
        step(1, mk(0, 0, 0, 5'd6, 20'h0AAAA, 8'h77), 0);
        step(0, '0, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t5_req", req, 0);
        end
        step(0, '0, 0);
        chk("t5_credits", n_cred, 1);
        chk("t5_err", err, 1);
        chk("t5_ov", n_ov, 0);

        // asynchronous reset mid-packet
        do_reset();
        f0 = mk(1, 0, 0, 5'd8, 20'h00F00, 8'hB0);
        f1 = mk(0, 0, 0, 5'd0, 20'h00000, 8'hB1);
        f2 = mk(0, 0, 0, 5'd0, 20'h00000, 8'hB2);
        expect_flit(f0);
        step(1, f0, 1);
        step(1, f1, 1);
        step(1, f2, 1);
        step(0, '0, 1);
        wait_ov("t6_first", d);
        chk("t6_req_before", req, 1);
        #2 rst_ = 1'b0;
        #1;
        chk("t6_req_rst", req, 0);
        chk("t6_ovalid_rst", ovalid, 0);
        chk("t6_ocredit_rst", ocredit, 0);
        exp_q.delete();
        grant = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_ = 1'b1;
        n_cred = 0;
        n_ov = 0;
        idle(4, 0);
        chk("t6_no_credits", n_cred, 0);
        chk("t6_no_out", n_ov, 0);
        f0 = mk(1, 1, 1, 5'd13, 20'h01010, 8'hC3);
        expect_flit(f0);
        step(1, f0, 1);
        step(0, '0, 1);
        wait_ov("t6_fresh", d);
        chk("t6_port", req_port, 3'd3);
        idle(3, 0);
        chk("t6_credits", n_cred, 1);

        // randomized packets through a credit-honouring upstream
        do_reset();
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            um  = 1'($urandom_range(0, 1));
            a0  = 5'($urandom_range(0, 19));
            a1  = 20'($urandom);
            for (int k = 0; k < len; k++) begin
                f0 = mk(k == 0, k == len - 1, um, k == 0 ? a0 : 5'($urandom),
                        k == 0 ? a1 : 20'($urandom), 8'($urandom));
                src_q.push_back(f0);
                expect_flit(f0);
            end
        end
        total = src_q.size();
        sent = 0;
        for (int c = 0; c < 4000 && (src_q.size() != 0 || exp_q.size() != 0); c++) begin
            g = $urandom_range(0, 3) != 0;
            if (src_q.size() != 0 && sent - n_cred < DEPTH && $urandom_range(0, 3) != 0) begin
                step(1, src_q.pop_front(), g);
                sent++;
            end else begin
                step(0, '0, g);
            end
        end
        idle(3, 1);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_sent", sent, total);
        chk("rnd_credits", n_cred, total);
        chk("rnd_out", n_ov, total);
        chk("rnd_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
